// File: rtl/alt_vipcts131_common_ctrl_packet_encoder_par.sv
// Control-packet encoder for a parallel-symbol video stream.
// Each video frame is preceded by a video header. A control packet carrying
// width/height/interlace nibbles is inserted between frames when it is
// requested. The output is a single registered stage with Avalon-ST
// ready-latency-0 handshaking.
module alt_vipcts131_common_ctrl_packet_encoder_par #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       din_valid,
    output logic                                       din_ready,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                       din_eop,
    output logic                                       dout_valid,
    input  logic                                       dout_ready,
    output logic                                       dout_sop,
    output logic                                       dout_eop,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    input  logic [15:0]                                width,
    input  logic [15:0]                                height,
    input  logic [3:0]                                 interlaced,
    input  logic                                       ctrl_send,
    output logic                                       ctrl_busy
);

    localparam int DW      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int N_BEATS = (9 + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;
    localparam logic [3:0]    LAST_BEAT     = 4'(N_BEATS - 1);
    localparam logic [DW-1:0] CTRL_HDR_BEAT = {{(DW-4){1'b0}}, 4'hF};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CTRL_HDR  = 3'd1,
        ST_CTRL_DATA = 3'd2,
        ST_VID_HDR   = 3'd3,
        ST_VIDEO     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic            busy_q, busy_d;
    logic [15:0]     width_q, width_d;
    logic [15:0]     height_q, height_d;
    logic [3:0]      interlaced_q, interlaced_d;
    logic            dout_valid_q, dout_valid_d;
    logic            dout_sop_q, dout_sop_d;
    logic            dout_eop_q, dout_eop_d;
    logic [DW-1:0]   dout_data_q, dout_data_d;
    logic            dout_ctrl_q, dout_ctrl_d;   // current output beat belongs to a control packet
    logic            accept_s;
    logic            adv_s;
    logic            out_acc_s;
    logic [DW-1:0]   ctrl_beat_s;

    // Nibble k of the control payload: w3,w2,w1,w0,h3,h2,h1,h0,interlaced.
    function automatic logic [3:0] ctrl_nibble(input logic [5:0] idx, input logic [15:0] w,
                                               input logic [15:0] h, input logic [3:0] il);
        case (idx)
            6'd0:    ctrl_nibble = w[15:12];
            6'd1:    ctrl_nibble = w[11:8];
            6'd2:    ctrl_nibble = w[7:4];
            6'd3:    ctrl_nibble = w[3:0];
            6'd4:    ctrl_nibble = h[15:12];
            6'd5:    ctrl_nibble = h[11:8];
            6'd6:    ctrl_nibble = h[7:4];
            6'd7:    ctrl_nibble = h[3:0];
            6'd8:    ctrl_nibble = il;
            default: ctrl_nibble = 4'h0;
        endcase
    endfunction

    assign accept_s   = ctrl_send & ~busy_q;
    assign adv_s      = dout_ready | ~dout_valid_q;
    assign out_acc_s  = dout_valid_q & dout_ready;
    assign din_ready  = (state_q == ST_VIDEO) & adv_s;
    assign dout_valid = dout_valid_q;
    assign dout_sop   = dout_sop_q;
    assign dout_eop   = dout_eop_q;
    assign dout_data  = dout_data_q;
    assign ctrl_busy  = busy_q;

    // Assemble the control-data beat selected by the beat counter, lowest symbol first.
    always_comb begin
        ctrl_beat_s = '0;
        for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
            ctrl_beat_s[s*BITS_PER_SYMBOL +: 4] =
                ctrl_nibble(6'(cnt_q) * 6'(SYMBOLS_PER_BEAT) + 6'(s),
                            width_q, height_q, interlaced_q);
        end
    end

    // Next-state, request bookkeeping and output-stage loading.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q | accept_s;
        busy_d       = busy_q;
        width_d      = width_q;
        height_d     = height_q;
        interlaced_d = interlaced_q;
        dout_valid_d = dout_valid_q;
        dout_sop_d   = dout_sop_q;
        dout_eop_d   = dout_eop_q;
        dout_data_d  = dout_data_q;
        dout_ctrl_d  = dout_ctrl_q;

        if (accept_s) begin
            busy_d       = 1'b1;
            width_d      = width;
            height_d     = height;
            interlaced_d = interlaced;
        end else if (out_acc_s && dout_eop_q && dout_ctrl_q) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        // An accepted beat empties the stage unless a new beat is loaded below.
        if (out_acc_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q || accept_s) begin
                    state_d   = ST_CTRL_HDR;
                    pending_d = 1'b0;
                end else if (din_valid) begin
                    state_d = ST_VID_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CTRL_HDR: begin
                if (adv_s) begin
                    dout_valid_d = 1'b1;
                    dout_sop_d   = 1'b1;
                    dout_eop_d   = 1'b0;
                    dout_data_d  = CTRL_HDR_BEAT;
                    dout_ctrl_d  = 1'b1;
                    cnt_d        = 4'd0;
                    state_d      = ST_CTRL_DATA;
                end else begin
                    state_d = ST_CTRL_HDR;
                end
            end
            ST_CTRL_DATA: begin
                if (adv_s) begin
                    dout_valid_d = 1'b1;
                    dout_sop_d   = 1'b0;
                    dout_eop_d   = (cnt_q == LAST_BEAT);
                    dout_data_d  = ctrl_beat_s;
                    dout_ctrl_d  = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = 4'd0;
                        state_d = ST_VID_HDR;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_CTRL_DATA;
                end
            end
            ST_VID_HDR: begin
                if (adv_s) begin
                    dout_valid_d = 1'b1;
                    dout_sop_d   = 1'b1;
                    dout_eop_d   = 1'b0;
                    dout_data_d  = '0;
                    dout_ctrl_d  = 1'b0;
                    state_d      = ST_VIDEO;
                end else begin
                    state_d = ST_VID_HDR;
                end
            end
            ST_VIDEO: begin
                if (adv_s && din_valid) begin
                    dout_valid_d = 1'b1;
                    dout_sop_d   = 1'b0;
                    dout_eop_d   = din_eop;
                    dout_data_d  = din_data;
                    dout_ctrl_d  = 1'b0;
                    if (din_eop) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_VIDEO;
                    end
                end else begin
                    state_d = ST_VIDEO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output-stage registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            width_q      <= 16'd0;
            height_q     <= 16'd0;
            interlaced_q <= 4'd0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_data_q  <= '0;
            dout_ctrl_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            width_q      <= width_d;
            height_q     <= height_d;
            interlaced_q <= interlaced_d;
            dout_valid_q <= dout_valid_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
            dout_data_q  <= dout_data_d;
            dout_ctrl_q  <= dout_ctrl_d;
        end
    end

endmodule

// File: doc/alt_vipcts131_common_ctrl_packet_encoder_par.md
ALT_VIPCTS131_COMMON_CTRL_PACKET_ENCODER_PAR -- requirements
Module: alt_vipcts131_common_ctrl_packet_encoder_par

Interface
REQ-001 SHALL have parameter BITS_PER_SYMBOL, default 8, bits per symbol (legal 4..16).
REQ-002 SHALL have parameter SYMBOLS_PER_BEAT, default 3, symbols per beat (legal 1..4); DW = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT.
REQ-003 SHALL have port clk  in  1  sole clock; all flops rise on clk.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
REQ-005 SHALL have port din_valid  in  1, din_ready  out  1, din_data  in  DW, din_eop  in  1: sink for video payload only, din_eop marks the last video beat.
REQ-006 SHALL have port dout_valid  out  1, dout_ready  in  1, dout_sop  out  1, dout_eop  out  1, dout_data  out  DW: Avalon-ST source, ready latency 0.
REQ-007 SHALL have port width  in  16, height  in  16, interlaced  in  4: control-packet field values.
REQ-008 SHALL have port ctrl_send  in  1 (request) and ctrl_busy  out  1 (request not yet fully transmitted).

Function
REQ-009 SHALL accept a request when ctrl_send=1 and ctrl_busy=0, capturing width/height/interlaced into shadow registers that cycle; requests while ctrl_busy=1 are ignored.
REQ-010 SHALL drive ctrl_busy=1 from the cycle after acceptance until the cycle after the control-packet eop beat is accepted downstream.
REQ-011 SHALL use states IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, VIDEO.
REQ-012 IDLE: if request pending -> CTRL_HDR; else if din_valid=1 -> VID_HDR; else stay; pending request has priority over waiting video.
REQ-013 CTRL_HDR: emit one beat, sop=1, symbol0=0xF, other symbols 0; -> CTRL_DATA.
REQ-014 CTRL_DATA: emit N=ceil(9/SYMBOLS_PER_BEAT) beats carrying nibbles w3,w2,w1,w0,h3,h2,h1,h0,int in order, lowest symbol first, nibble in symbol bits [3:0], unused bits/symbols 0; beat counter 0..N-1; eop=1 on beat N-1; -> VID_HDR.
REQ-015 VID_HDR: emit one beat, sop=1, symbol0=0x0, others 0; -> VIDEO.
REQ-016 VIDEO: pass din_data; eop=din_eop; on accepted beat with din_eop=1 -> IDLE.
REQ-017 A control request arriving mid-frame SHALL be held pending and sent only after the current video eop, never interrupting a packet.
REQ-018 Output SHALL be a registered stage: dout_* update when dout_ready=1 or dout_valid=0; latency din->dout exactly 1 cycle when unstalled.
REQ-019 din_ready SHALL equal (state==VIDEO) & (dout_ready | ~dout_valid); din_ready=0 in all other states.
REQ-020 dout_data/sop/eop SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-021 Full throughput: with dout_ready held 1 and din_valid held 1, one beat per cycle, no bubbles between VID_HDR and first video beat.
REQ-022 Simultaneous ctrl_send acceptance and video eop acceptance: request becomes pending; next state IDLE then CTRL_HDR.

Reset
REQ-023 On rst=0: state=IDLE, dout_valid=0, dout_sop=0, dout_eop=0, dout_data=0, din_ready=0, ctrl_busy=0, shadow registers=0, pending=0, beat counter=0.
REQ-024 Reset mid-packet SHALL abandon the packet with no eop emitted; after release behaviour is as from power-up.

Verification
REQ-025 SPB=3, width=0x0280, height=0x01E0, interlaced=0x3, ctrl_send pulse in IDLE, dout_ready=1 -> beats 0x00000F(sop), 0x080200, 0x010000, 0x03000E(eop), then 0x000000(sop) when din_valid=1.
REQ-026 SPB=1 same values -> 10 control beats, data beats 0,2,8,0,0,1,E,0,3, eop on 10th.
REQ-027 SPB=4 -> 3 data beats, last beat symbol0=0x3, symbols1-3=0, eop=1.
REQ-028 ctrl_send during a 4-beat video frame -> frame completes intact with eop on beat 4, control packet follows; ctrl_busy=1 throughout.
REQ-029 Random dout_ready backpressure (50%) over 100 frames -> output sequence identical to unstalled run, no data change while stalled.
REQ-030 rst=0 asserted during CTRL_DATA beat 1 -> all outputs 0 within the same cycle; after release, ctrl_send produces a complete, correct packet.
